// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), one bit per clock,
// LSB first. The borrow chain of a ripple subtractor is folded in time into a
// single running-borrow flop. Start/busy/done handshake; results are registered
// and hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    // Counter must hold 0..WIDTH-1; the +1 keeps CW >= 1 even for WIDTH=1.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic br_in);
        logic d;
        logic br_out;
        d      = x ^ y ^ br_in;
        br_out = (~x & y) | (~(x ^ y) & br_in);
        return {br_out, d};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [1:0]       cell_s;
    logic [WIDTH-1:0] res_next_s;

    // One bit of the subtraction: LSBs of the operand shifters plus running borrow.
    always_comb begin
        cell_s     = sub_bit(a_sh_q[0], b_sh_q[0], br_q);
        // New difference bit enters at the MSB; after WIDTH steps the LSB sits at bit 0.
        res_next_s = WIDTH'({cell_s[0], res_q} >> 1);
    end

    // Next-state and datapath control; every register holds unless told otherwise.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Accept: operands captured here only; outputs keep the old result.
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // start is deliberately ignored here: no queuing, no restart.
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_next_s;
                br_d   = cell_s[1];
                cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_BIT) begin
                    diff_d   = res_next_s;
                    borrow_d = cell_s[1];
                    zero_d   = (res_next_s == '0);
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_SHIFT;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1, against an
// arithmetic reference model (plain integer subtraction).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic [7:0] diff8;
    logic       borrow8, zero8, busy8, done8;
    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic [0:0] diff1;
    logic       borrow1, zero1, busy1, done1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_diff8 = 8'h00;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .diff(diff8), .borrow(borrow8), .zero(zero8), .busy(busy8), .done(done8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .diff(diff1), .borrow(borrow1), .zero(zero1), .busy(busy1), .done(done1)
    );

    // Reference: {zero, borrow, diff} from integer arithmetic modulo 2^w.
    function automatic logic [33:0] model(input int unsigned x, input int unsigned y, input int w);
        longint m, d;
        m = longint'(1) << w;
        d = ((longint'(x) - longint'(y)) % m + m) % m;
        return {(d == 0), (x < y), 32'(d)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge on the WIDTH=8 unit.
    task automatic start_op8(input logic [7:0] ea, input logic [7:0] eb);
        start8 = 1'b1; a8 = ea; b8 = eb;
        tick();
        start8 = 1'b0; a8 = $urandom(); b8 = $urandom();
        chk("accept_busy", busy8, 1);
        chk("accept_done", done8, 0);
        chk("accept_hold_diff", diff8, last_diff8);
    endtask

    // Remaining WIDTH cycles; optional ignored start pulse before edge inj (1..7).
    task automatic wait_op8(input logic [7:0] ea, input logic [7:0] eb, input int inj,
                            input logic [7:0] ga, input logic [7:0] gb);
        logic [33:0] e;
        e = model(ea, eb, 8);
        for (int i = 1; i < 8; i++) begin
            if (i == inj) begin
                start8 = 1'b1; a8 = ga; b8 = gb;
            end else begin
                start8 = 1'b0;
            end
            tick();
            chk("shift_busy", busy8, 1);
            chk("shift_done", done8, 0);
            chk("shift_hold_diff", diff8, last_diff8);
        end
        start8 = 1'b0;
        tick();
        chk("done_pulse", done8, 1);
        chk("done_busy", busy8, 0);
        chk("diff", diff8, e[7:0]);
        chk("borrow", borrow8, e[32]);
        chk("zero", zero8, e[33]);
        last_diff8 = e[7:0];
    endtask

    task automatic run_op8(input logic [7:0] ea, input logic [7:0] eb);
        start_op8(ea, eb);
        wait_op8(ea, eb, 0, 8'h00, 8'h00);
        tick();
        chk("after_done", done8, 0);
        chk("after_busy", busy8, 0);
    endtask

    task automatic run_op1(input logic ea, input logic eb);
        logic [33:0] e;
        e = model(32'(ea), 32'(eb), 1);
        start1 = 1'b1; a1 = ea; b1 = eb;
        tick();
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        chk("w1_done_early", done1, 0);
        tick();
        chk("w1_done", done1, 1);
        chk("w1_diff", diff1, e[0]);
        chk("w1_borrow", borrow1, e[32]);
        chk("w1_zero", zero1, e[33]);
        tick();
        chk("w1_done_clear", done1, 0);
    endtask

    initial begin
        logic [7:0] ra, rb, ga, gb;

        // Reset state.
        tick();
        tick();
        chk("rst_diff", diff8, 0);
        chk("rst_borrow", borrow8, 0);
        chk("rst_zero", zero8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        rst = 1'b0;
        tick();

        // Directed operations.
        run_op8(8'h5A, 8'h23);
        run_op8(8'h10, 8'h20);
        run_op8(8'h42, 8'h42);

        // start during SHIFT is ignored; no second done afterwards.
        start_op8(8'h05, 8'h03);
        wait_op8(8'h05, 8'h03, 4, 8'hFF, 8'h01);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_second_done", done8, 0);
            chk("no_second_busy", busy8, 0);
        end

        // Reset mid-operation.
        start_op8(8'hFF, 8'h00);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_diff", diff8, 0);
        chk("midrst_borrow", borrow8, 0);
        chk("midrst_zero", zero8, 0);
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        last_diff8 = 8'h00;
        tick();
        chk("midrst_idle_busy", busy8, 0);
        run_op8(8'h80, 8'h01);

        // Back-to-back: new start accepted on the DONE cycle.
        start_op8(8'h5A, 8'h23);
        wait_op8(8'h5A, 8'h23, 0, 8'h00, 8'h00);
        start_op8(8'h00, 8'h01);
        wait_op8(8'h00, 8'h01, 0, 8'h00, 8'h00);
        tick();
        chk("b2b_done_clear", done8, 0);

        // Randomized operations with ignored start pulses mid-shift.
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom());
            rb = 8'($urandom());
            if (n % 6 == 0) rb = ra;
            ga = 8'($urandom());
            gb = 8'($urandom());
            start_op8(ra, rb);
            wait_op8(ra, rb, int'($urandom_range(0, 7)), ga, gb);
            if (n % 2 == 0) begin
                tick();
                chk("rnd_idle_done", done8, 0);
            end
        end

        // WIDTH=1 sweep plus a few random pairs.
        run_op1(1'b0, 1'b0);
        run_op1(1'b1, 1'b0);
        run_op1(1'b0, 1'b1);
        run_op1(1'b1, 1'b1);
        for (int n = 0; n < 6; n++) begin
            run_op1(1'($urandom()), 1'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
